instr_issue_seq: RTL and testbench
==================================

# instr_issue_seq

Instruction issue sequencer that sits in front of `mipscpu` and drives its `instrWord` / `newInstr` inputs. It buffers a program of 32-bit instruction words in a small FIFO. On `start` it feeds the words to the CPU one at a time, with a fixed settle gap between issues, so the multi-cycle core finishes each instruction before the next pulse. This replaces hand-timed instruction delivery in benches and system wrappers.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `GAP`, 8: idle cycles after each `newInstr` pulse before the next setup; range 1..255.

Ports:
- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  loader offers `push_instr`.
- `push_instr`  in  32  instruction word to enqueue.
- `push_ready`  out  1  FIFO can accept; equals `!full`.
- `start`  in  1  single-cycle request to begin issuing the queued program.
- `instrWord`  out  32  instruction to the CPU; registered.
- `newInstr`  out  1  one-cycle issue strobe to the CPU; registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the queue drains.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Enqueue occurs when `push_valid && push_ready`.
  - Pushes are accepted in every state, including while issuing.
  - `push_ready` depends only on the current `full`. A same-cycle pop does not raise it.
- State machine: IDLE, SETUP, PULSE, WAIT, DONE.
  - IDLE: if `start` is high and `count != 0`, load `instrWord` with the FIFO head and go to SETUP. If `start` is high and the queue is empty, `start` is ignored.
  - SETUP (1 cycle): `instrWord` is stable. Set `newInstr` high, pop the head, go to PULSE.
  - PULSE (1 cycle): clear `newInstr`, load the gap counter with GAP-1, go to WAIT.
  - WAIT: decrement the counter. When it reaches 0:
    - if `count != 0`, load `instrWord` with the head and go to SETUP;
    - otherwise go to DONE.
  - DONE (1 cycle): assert `done`, then go to IDLE.
- `start` is ignored in every state except IDLE.
- `instrWord` holds the last issued word until the next load. It is never driven with an unpopped value while `newInstr` is high.
- A push into an empty queue during WAIT is issued if it arrives before the counter reaches 0.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `count`.

## Timing
- Reset values: state IDLE, `instrWord` 0, `newInstr` 0, `done` 0, `busy` 0, `count` 0, pointers 0.
- Reset in any state aborts immediately and discards all queued words. The cycle after reset is a clean IDLE, with no stray `newInstr` or `done`.
- With `start` sampled at edge k:
  - `instrWord` is valid after edge k.
  - `newInstr` is high from edge k+1 to edge k+2.
- Issue period is GAP+2 cycles per instruction.
- `instrWord` is stable for at least one full cycle before `newInstr` rises.
- For N words, `done` asserts N·(GAP+2) cycles after the `start` edge.
- `newInstr` is always exactly one cycle wide.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W = 32`;
  - `issue_state_t` enum (IDLE, SETUP, PULSE, WAIT, DONE);
  - instruction opcode/funct constants (LW 6'b100011, SW 6'b101011, R-type 0, ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101) for reuse by benches.
- Sub-module `instr_fifo` (parameter DEPTH):
  - synchronous single-clock FIFO with push/pop, `full`, `empty`, `count`;
  - pop on empty and push on full are ignored.
- The FSM and gap counter live in `instr_issue_seq`.

## Test plan
- **Basic program.** Reset, then push 8C010000, 8C020001, 8C030002, 00222020, 00832022, AC040003 with data memory [0..2] = 10, 22, 6, then `start`.
  - Required: six one-cycle `newInstr` pulses spaced GAP+2 cycles apart, with the words in push order.
  - Required: `done` pulses once; CPU memory[3] = 26.
- **Full queue.** Push DEPTH words without `start`.
  - Required: `count` = DEPTH and `push_ready` = 0.
  - Required: a (DEPTH+1)th push is not accepted; after issue, exactly DEPTH pulses occur.
- **Push during WAIT.** Push 1 word, `start`, then push 00622020 during WAIT.
  - Required: 2 pulses, no DONE between them, `done` only after the second.
- **Spurious starts.**
  - `start` with an empty queue: `busy` stays 0 and there are no pulses.
  - `start` reasserted while `busy`: no change in pulse count or timing.
- **Reset mid-run.** Assert `Reset` one cycle after the second pulse of a 5-word run.
  - Required: `count` = 0, `instrWord` = 0, no further `newInstr`, no `done`.
  - Required: a new 1-word run afterwards behaves normally.
- **Pointer wrap.** Issue three runs of 5 words each with DEPTH = 8.
  - Required: the words come out in correct order across pointer wrap-around.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, issue sequencer states and
// MIPS opcode/funct encodings used by the sequencer and its benches.
package cpu_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } issue_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

endpackage

// File: rtl/instr_fifo.sv
// Single-clock instruction FIFO with show-ahead head output; full/empty are
// decoded from the occupancy count, pointers wrap modulo DEPTH.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_push_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage is left uninitialised; only pointers and count are reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue_seq.sv
// Feeds queued instruction words to the multi-cycle CPU one at a time,
// holding a fixed settle gap between newInstr strobes.
module instr_issue_seq
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         push_valid,
    input  logic [INSTR_W-1:0]           push_instr,
    output logic                         push_ready,
    input  logic                         start,
    output logic [INSTR_W-1:0]           instrWord,
    output logic                         newInstr,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

    issue_state_t       r_state;
    issue_state_t       w_state_nxt;
    logic [7:0]         r_gap_cnt;
    logic [7:0]         w_gap_nxt;
    logic [INSTR_W-1:0] r_word;
    logic [INSTR_W-1:0] w_word_nxt;
    logic               r_new;
    logic               w_new_nxt;
    logic               w_pop;
    logic [INSTR_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_push      (push_valid),
        .i_push_data (push_instr),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (count)
    );

    assign push_ready = !w_full;
    assign instrWord  = r_word;
    assign newInstr   = r_new;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_word    <= '0;
            r_new     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_word    <= w_word_nxt;
            r_new     <= w_new_nxt;
        end
    end

    // The word is loaded one state ahead of the strobe so it is stable for a
    // full cycle before newInstr rises; the pop happens with the strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_word_nxt  = r_word;
        w_new_nxt   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !w_empty) begin
                    w_word_nxt  = w_head;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_new_nxt   = 1'b1;
                w_pop       = 1'b1;
                w_state_nxt = PULSE;
            end
            PULSE: begin
                w_gap_nxt   = GAP_LOAD;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_gap_cnt == '0) begin
                    if (!w_empty) begin
                        w_word_nxt  = w_head;
                        w_state_nxt = SETUP;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - 8'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_issue_seq.sv
// Scoreboard bench for instr_issue_seq with a tiny CPU model consuming the
// issued words.
module tb_instr_issue_seq;
    import cpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int GAP   = 8;
    localparam int PER   = GAP + 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        push_valid;
    logic [31:0] push_instr;
    logic        push_ready;
    logic        start;
    logic [31:0] instrWord;
    logic        newInstr;
    logic        busy;
    logic        done;
    logic [3:0]  count;

    instr_issue_seq #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .push_valid (push_valid),
        .push_instr (push_instr),
        .push_ready (push_ready),
        .start      (start),
        .instrWord  (instrWord),
        .newInstr   (newInstr),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          fails  = 0;
    int          cycle  = 0;
    int          run_start = 0;
    int          run_idx   = 0;
    int          pulses    = 0;
    int          done_cnt  = 0;
    logic        prev_ni   = 1'b0;
    logic [31:0] prev_word = '0;
    logic [31:0] sb[$];
    logic [31:0] regs [32];
    logic [31:0] mem  [16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    task automatic cpu_exec(input logic [31:0] w);
        logic [3:0]  addr;
        addr = 4'(regs[w[25:21]] + {{16{w[15]}}, w[15:0]});
        if (w[31:26] == OP_LW) begin
            if (w[20:16] != 5'd0) regs[w[20:16]] = mem[addr];
        end else if (w[31:26] == OP_SW) begin
            mem[addr] = regs[w[20:16]];
        end else if (w[31:26] == OP_RTYPE && w[15:11] != 5'd0) begin
            case (w[5:0])
                FN_ADD:  regs[w[15:11]] = regs[w[25:21]] + regs[w[20:16]];
                FN_SUB:  regs[w[15:11]] = regs[w[25:21]] - regs[w[20:16]];
                FN_AND:  regs[w[15:11]] = regs[w[25:21]] & regs[w[20:16]];
                FN_OR:   regs[w[15:11]] = regs[w[25:21]] | regs[w[20:16]];
                default: ;
            endcase
        end
    endtask

    always @(posedge Clk) cycle <= cycle + 1;

    // Monitor: pops the scoreboard on every strobe and checks exact timing.
    always @(negedge Clk) begin
        logic [31:0] exp_w;
        if (!Reset) begin
            if (newInstr) begin
                chk("pulse_width", 32'(prev_ni), 32'd0);
                chk("setup_stable", prev_word, instrWord);
                chk("pulse_time", 32'(cycle), 32'(run_start + 1 + run_idx * PER));
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    chk("instr_word", instrWord, exp_w);
                end
                cpu_exec(instrWord);
                run_idx++;
                pulses++;
            end
            if (done) begin
                chk("done_time", 32'(cycle), 32'(run_start + run_idx * PER));
                chk("done_sb_left", 32'(sb.size()), 32'd0);
                done_cnt++;
            end
        end
        prev_ni   = newInstr;
        prev_word = instrWord;
    end

    task automatic push_word(input logic [31:0] w, input logic exp_acc);
        @(negedge Clk);
        push_valid = 1'b1;
        push_instr = w;
        chk("push_ready", 32'(push_ready), 32'(exp_acc));
        if (exp_acc) sb.push_back(w);
        @(posedge Clk);
        #1 push_valid = 1'b0;
    endtask

    task automatic start_run();
        @(negedge Clk);
        start     = 1'b1;
        run_start = cycle + 1;
        run_idx   = 0;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (done_cnt != d0) break;
        end
        @(negedge Clk);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int p0;
        int d0;
        logic [31:0] prog [6];
        prog = '{32'h8C010000, 32'h8C020001, 32'h8C030002,
                 32'h00222020, 32'h00832022, 32'hAC040003};
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'd10; mem[1] = 32'd22; mem[2] = 32'd6;
        Reset = 1'b1; push_valid = 1'b0; push_instr = '0; start = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_instrWord", instrWord, 32'd0);
        chk("rst_newInstr", 32'(newInstr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd1);

        // Basic program through the CPU model.
        for (int i = 0; i < 6; i++) push_word(prog[i], 1'b1);
        start_run();
        wait_done(6 * PER + 20);
        chk("basic_mem3", mem[3], 32'd26);

        // Spurious start on an empty queue.
        p0 = pulses;
        start_run();
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("empty_start_busy", 32'(busy), 32'd0);
        end
        chk("empty_start_pulses", 32'(pulses), 32'(p0));

        // Full queue and rejected extra push.
        for (int i = 0; i < DEPTH; i++) push_word(32'h2000_0000 + 32'(i), 1'b1);
        @(negedge Clk);
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_ready", 32'(push_ready), 32'd0);
        push_word(32'h2BAD_BEEF, 1'b0);
        p0 = pulses;
        start_run();
        wait_done(DEPTH * PER + 20);
        chk("full_pulses", 32'(pulses - p0), 32'(DEPTH));

        // Push into an empty queue during WAIT extends the run.
        p0 = pulses;
        d0 = done_cnt;
        push_word(32'h00022020, 1'b1);
        start_run();
        repeat (4) @(negedge Clk);
        chk("wait_push_no_done", 32'(done_cnt - d0), 32'd0);
        push_word(32'h00622020, 1'b1);
        wait_done(2 * PER + 20);
        chk("wait_push_pulses", 32'(pulses - p0), 32'd2);

        // Pointer wrap with repeated starts while busy.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) push_word(32'h1000_0000 + 32'(r * 16 + i), 1'b1);
            start_run();
            repeat (PER + 3) @(negedge Clk);
            start = 1'b1;
            @(negedge Clk);
            start = 1'b0;
            wait_done(5 * PER + 20);
        end

        // Reset mid-run.
        p0 = pulses;
        for (int i = 0; i < 5; i++) push_word(32'h1100_0000 + 32'(i), 1'b1);
        start_run();
        for (int i = 0; i < 4 * PER; i++) begin
            @(negedge Clk);
            if (pulses == p0 + 2) break;
        end
        chk("rst_mid_two_pulses", 32'(pulses - p0), 32'd2);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        sb.delete();
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_word", instrWord, 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        p0 = pulses;
        d0 = done_cnt;
        repeat (5 * PER) @(negedge Clk);
        chk("rst_mid_no_pulse", 32'(pulses), 32'(p0));
        chk("rst_mid_no_done", 32'(done_cnt), 32'(d0));
        push_word(32'h1200_0001, 1'b1);
        start_run();
        wait_done(PER + 20);
        chk("post_rst_pulses", 32'(pulses - p0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "timeout");
    end

endmodule
